me_sad_engine: RTL and testbench



---
 rtl/me_sad_engine_pkg.sv | 25 ++
 rtl/me_row_sad.sv | 19 +
 rtl/me_sad_engine.sv | 173 +++++++++++++++++
 tb/tb_me_sad_engine.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_sad_engine_pkg.sv
// Shared types and constants for the full-search SAD engine.
package me_sad_engine_pkg;

  localparam int PIX_W    = 8;
  localparam int BLK      = 16;
  localparam int NCAND_H  = 8;
  localparam int NCAND_V  = 8;
  localparam int SAD_W    = 16;
  localparam int ROWSAD_W = 12;
  localparam int NCAND    = NCAND_H * NCAND_V;
  localparam int MV_OFS   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_COMPARE
  } state_t;

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/me_row_sad.sv
// Sum of absolute differences between one 16-pixel current row and one
// 16-pixel reference slice.
module me_row_sad
  import me_sad_engine_pkg::*;
(
  input  logic [BLK*PIX_W-1:0] cur,
  input  logic [BLK*PIX_W-1:0] ref_px,
  output logic [ROWSAD_W-1:0]  sad
);

  // Adder tree over the 16 per-pixel absolute differences.
  always_comb begin
    sad = '0;
    for (int p = 0; p < BLK; p++) begin
      sad = sad + ROWSAD_W'(abs_diff(cur[p*PIX_W +: PIX_W], ref_px[p*PIX_W +: PIX_W]));
    end
  end

endmodule

// File: rtl/me_sad_engine.sv
// Full-search SAD engine: accumulates SAD for 8x8 candidates over a
// streamed 23-row reference window, then scans for the minimum.
// Build option: define ME_ZERO_BIAS_EN to favour the (0,0) candidate by
// ZERO_BIAS during the minimum scan.
module me_sad_engine
  import me_sad_engine_pkg::*;
#(
  parameter int ROWS      = 23,
  parameter int ZERO_BIAS = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [BLK*PIX_W-1:0]               cur_in,
  input  logic                               cur_we,
  input  logic [3:0]                         cur_addr,
  input  logic                               start,
  input  logic [(BLK+NCAND_H-1)*PIX_W-1:0]   ref_row,
  input  logic                               ref_valid,
  input  logic                               ref_first,
  output logic                               busy,
  output logic                               done,
  output logic [3:0]                         best_mvx,
  output logic [3:0]                         best_mvy,
  output logic [SAD_W-1:0]                   best_sad
);

`ifdef ME_ZERO_BIAS_EN
  localparam logic [SAD_W-1:0] BIAS = SAD_W'(ZERO_BIAS);
`else
  // Bias disabled; the parameter stays referenced but contributes nothing.
  localparam logic [SAD_W-1:0] BIAS = SAD_W'(ZERO_BIAS * 0);
`endif

  localparam int CAND_ZERO = MV_OFS * NCAND_H + MV_OFS;

  state_t               state;
  logic [4:0]           j;
  logic [6:0]           k;
  logic [SAD_W-1:0]     cmp_sad;
  logic [5:0]           cmp_idx;

  logic [BLK*PIX_W-1:0] cur_mem [BLK];
  logic [BLK*PIX_W-1:0] cur_sel [NCAND_V];
  logic [NCAND_V-1:0]   row_en;
  logic [NCAND_V-1:0]   s1_en;
  logic [ROWSAD_W-1:0]  row_sad [NCAND];
  logic [ROWSAD_W-1:0]  s1_sad  [NCAND];
  logic [SAD_W-1:0]     accum   [NCAND];

  logic                 accept, restart, arm;
  logic [4:0]           jr;
  logic [SAD_W-1:0]     cand_raw, cand;
  logic [SAD_W:0]       biased;

  assign arm     = (state == S_IDLE) && start;
  assign accept  = (state == S_ACCUM) && ref_valid;
  assign restart = accept && ref_first;
  // A ref_first row is always treated as window row 0.
  assign jr      = restart ? 5'd0 : j;

  // Current-block row store; frozen while a search is running.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && cur_we) cur_mem[cur_addr] <= cur_in;
  end

  // Per vertical offset, pick the block row that lines up with reference row jr.
  always_comb begin
    for (int v = 0; v < NCAND_V; v++) begin
      cur_sel[v] = cur_mem[4'(jr - 5'(v))];
      row_en[v]  = (jr >= 5'(v)) && ((jr - 5'(v)) <= 5'd15);
    end
  end

  for (genvar v = 0; v < NCAND_V; v++) begin : g_v
    for (genvar h = 0; h < NCAND_H; h++) begin : g_h
      me_row_sad u_row_sad (
        .cur    (cur_sel[v]),
        .ref_px (ref_row[h*PIX_W +: BLK*PIX_W]),
        .sad    (row_sad[v*NCAND_H + h])
      );
    end
  end

  // Stage 1 registers row SADs; stage 2 folds them into the accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_en <= '0;
      for (int i = 0; i < NCAND; i++) begin
        s1_sad[i] <= '0;
        accum[i]  <= '0;
      end
    end else begin
      s1_en <= accept ? row_en : '0;
      if (accept) begin
        for (int i = 0; i < NCAND; i++) s1_sad[i] <= row_sad[i];
      end
      // Clearing wins over a stage-2 add still in flight from the old window.
      if (arm || restart) begin
        for (int i = 0; i < NCAND; i++) accum[i] <= '0;
      end else begin
        for (int i = 0; i < NCAND; i++) begin
          if (s1_en[i / NCAND_H]) accum[i] <= accum[i] + SAD_W'(s1_sad[i]);
        end
      end
    end
  end

  // Candidate under scan, with the (0,0) bias clamped at zero.
  always_comb begin
    cand_raw = accum[k[5:0]];
    biased   = {1'b0, cand_raw} - {1'b0, BIAS};
    cand     = cand_raw;
    if (k[5:0] == 6'(CAND_ZERO)) cand = biased[SAD_W] ? '0 : biased[SAD_W-1:0];
  end

  // Sequencer: arm, accumulate rows, drain the pipeline, scan 64 candidates,
  // then publish the winner on the extra 65th compare cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      best_mvx <= '0;
      best_mvy <= '0;
      best_sad <= '1;
      j        <= '0;
      k        <= '0;
      cmp_sad  <= '1;
      cmp_idx  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ACCUM;
            busy  <= 1'b1;
            j     <= '0;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            j <= jr + 5'd1;
            if (jr == 5'(ROWS - 1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          state   <= S_COMPARE;
          k       <= '0;
          cmp_sad <= '1;
          cmp_idx <= '0;
        end
        S_COMPARE: begin
          if (k[6]) begin
            best_mvx <= {1'b0, cmp_idx[2:0]} - 4'(MV_OFS);
            best_mvy <= {1'b0, cmp_idx[5:3]} - 4'(MV_OFS);
            best_sad <= cmp_sad;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            if (cand < cmp_sad) begin
              cmp_sad <= cand;
              cmp_idx <= k[5:0];
            end
            k <= k + 7'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_sad_engine.sv
// Directed self-checking bench for me_sad_engine.
module tb_me_sad_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] cur_in;
  logic         cur_we;
  logic [3:0]   cur_addr;
  logic         start;
  logic [183:0] ref_row;
  logic         ref_valid;
  logic         ref_first;
  logic         busy;
  logic         done;
  logic [3:0]   best_mvx;
  logic [3:0]   best_mvy;
  logic [15:0]  best_sad;

  int checks = 0;
  int errors = 0;

  logic [7:0] cur_blk [16][16];
  logic [7:0] ref_win [23][23];

  me_sad_engine dut (
    .clk       (clk),
    .rst       (rst),
    .cur_in    (cur_in),
    .cur_we    (cur_we),
    .cur_addr  (cur_addr),
    .start     (start),
    .ref_row   (ref_row),
    .ref_valid (ref_valid),
    .ref_first (ref_first),
    .busy      (busy),
    .done      (done),
    .best_mvx  (best_mvx),
    .best_mvy  (best_mvy),
    .best_sad  (best_sad)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [183:0] ref_line(input int r);
    logic [183:0] l;
    for (int q = 0; q < 23; q++) l[q*8 +: 8] = ref_win[r][q];
    return l;
  endfunction

  task automatic set_cur_const(input logic [7:0] val);
    for (int r = 0; r < 16; r++)
      for (int p = 0; p < 16; p++) cur_blk[r][p] = val;
  endtask

  task automatic set_ref_const(input logic [7:0] val);
    for (int r = 0; r < 23; r++)
      for (int q = 0; q < 23; q++) ref_win[r][q] = val;
  endtask

  // Textured block (values below 8'h80) copied into an 8'hFF field at h=5, v=6.
  task automatic set_match_pattern();
    for (int r = 0; r < 16; r++)
      for (int p = 0; p < 16; p++) cur_blk[r][p] = 8'((r * 37 + p * 11 + 3) % 128);
    set_ref_const(8'hFF);
    for (int r = 0; r < 16; r++)
      for (int p = 0; p < 16; p++) ref_win[6 + r][5 + p] = cur_blk[r][p];
  endtask

  task automatic load_cur();
    for (int r = 0; r < 16; r++) begin
      for (int p = 0; p < 16; p++) cur_in[p*8 +: 8] = cur_blk[r][p];
      cur_addr = 4'(r);
      cur_we   = 1'b1;
      tick();
    end
    cur_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_row(input int r, input logic first);
    ref_row   = ref_line(r);
    ref_valid = 1'b1;
    ref_first = first;
    tick();
    ref_valid = 1'b0;
    ref_first = 1'b0;
  endtask

  task automatic send_window();
    for (int r = 0; r < 23; r++) send_row(r, r == 0);
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b expected busy=0 done=0", busy, done);
    end
    checks++;
    if (best_sad !== 16'hFFFF || best_mvx !== 4'h0 || best_mvy !== 4'h0) begin
      errors++;
      $display("FAIL reset_best: sad=%h mvx=%h mvy=%h expected sad=ffff mvx=0 mvy=0",
               best_sad, best_mvx, best_mvy);
    end
  endtask

  task automatic test_flat();
    int lat;
    set_cur_const(8'h80);
    set_ref_const(8'h80);
    load_cur();
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL flat_busy: busy=%b expected 1", busy);
    end
    send_window();
    wait_done(lat);
    checks++;
    if (lat !== 66) begin
      errors++;
      $display("FAIL flat_latency: got %0d cycles expected 66", lat);
    end
    checks++;
    if (best_sad !== 16'd0 || best_mvx !== 4'hC || best_mvy !== 4'hC || busy !== 1'b0) begin
      errors++;
      $display("FAIL flat_result: sad=%0d mvx=%h mvy=%h busy=%b expected sad=0 mvx=c mvy=c busy=0",
               best_sad, best_mvx, best_mvy, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || best_sad !== 16'd0) begin
      errors++;
      $display("FAIL flat_done_pulse: done=%b sad=%0d expected done=0 sad=0", done, best_sad);
    end
  endtask

  task automatic test_exact_match();
    int lat;
    set_match_pattern();
    load_cur();
    pulse_start();
    send_window();
    wait_done(lat);
    checks++;
    if (lat !== 66 || best_sad !== 16'd0 || best_mvx !== 4'h1 || best_mvy !== 4'h2) begin
      errors++;
      $display("FAIL exact_match: lat=%0d sad=%0d mvx=%h mvy=%h expected lat=66 sad=0 mvx=1 mvy=2",
               lat, best_sad, best_mvx, best_mvy);
    end
  endtask

  // Maximum SAD, with cur_we and start pulses mid-window that must be ignored.
  task automatic test_max_sad();
    int lat;
    set_cur_const(8'h00);
    set_ref_const(8'hFF);
    load_cur();
    pulse_start();
    for (int r = 0; r < 11; r++) send_row(r, r == 0);
    cur_in   = '1;
    cur_addr = 4'd3;
    cur_we   = 1'b1;
    tick();
    cur_we = 1'b0;
    pulse_start();
    for (int r = 11; r < 23; r++) send_row(r, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== 66) begin
      errors++;
      $display("FAIL max_latency: got %0d cycles expected 66", lat);
    end
    checks++;
    if (best_sad !== 16'hFF00 || best_mvx !== 4'hC || best_mvy !== 4'hC) begin
      errors++;
      $display("FAIL max_sad: sad=%h mvx=%h mvy=%h expected sad=ff00 mvx=c mvy=c",
               best_sad, best_mvx, best_mvy);
    end
  endtask

  // Gapped rows with three restarts; only the final 23 rows should count.
  task automatic test_gaps_restart();
    int lat;
    int bad_busy = 0;
    set_match_pattern();
    load_cur();
    pulse_start();
    for (int s = 0; s < 39; s++) begin
      if (s < 16) begin
        ref_row   = '0;
        ref_first = (s == 0) || (s == 5) || (s == 12);
      end else begin
        ref_row   = ref_line(s - 16);
        ref_first = (s == 16);
      end
      ref_valid = 1'b1;
      tick();
      ref_valid = 1'b0;
      ref_first = 1'b0;
      if (busy !== 1'b1) bad_busy++;
      if (s < 38) begin
        tick();
        if (busy !== 1'b1) bad_busy++;
      end
    end
    checks++;
    if (bad_busy !== 0) begin
      errors++;
      $display("FAIL gaps_busy: busy low on %0d sampled cycles expected 0", bad_busy);
    end
    wait_done(lat);
    checks++;
    if (lat !== 66 || best_sad !== 16'd0 || best_mvx !== 4'h1 || best_mvy !== 4'h2) begin
      errors++;
      $display("FAIL gaps_result: lat=%0d sad=%0d mvx=%h mvy=%h expected lat=66 sad=0 mvx=1 mvy=2",
               lat, best_sad, best_mvx, best_mvy);
    end
  endtask

  task automatic test_reset_in_compare();
    int lat;
    set_cur_const(8'h80);
    set_ref_const(8'h80);
    load_cur();
    pulse_start();
    send_window();
    for (int n = 0; n < 21; n++) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre_busy: busy=%b expected 1", busy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || best_sad !== 16'hFFFF) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b sad=%h expected busy=0 done=0 sad=ffff",
               busy, done, best_sad);
    end
    rst = 1'b0;
    set_cur_const(8'h00);
    set_ref_const(8'hFF);
    load_cur();
    pulse_start();
    send_window();
    wait_done(lat);
    checks++;
    if (lat !== 66 || best_sad !== 16'hFF00 || best_mvx !== 4'hC || best_mvy !== 4'hC) begin
      errors++;
      $display("FAIL abort_rerun: lat=%0d sad=%h mvx=%h mvy=%h expected lat=66 sad=ff00 mvx=c mvy=c",
               lat, best_sad, best_mvx, best_mvy);
    end
  endtask

  // Flat 8'h80 block; every window except (0,0) and (+2,-1) covers a
  // 8'h00 pixel (cost 128). Single off pixels give (+2,-1)=60, (0,0)=100.
  task automatic test_zero_bias();
    int lat;
    logic [3:0]  exp_mvx;
    logic [3:0]  exp_mvy;
    logic [15:0] exp_sad;
`ifdef ME_ZERO_BIAS_EN
    exp_mvx = 4'h0;
    exp_mvy = 4'h0;
    exp_sad = 16'd36;
`else
    exp_mvx = 4'h2;
    exp_mvy = 4'hF;
    exp_sad = 16'd60;
`endif
    set_cur_const(8'h80);
    set_ref_const(8'h00);
    for (int r = 4; r < 20; r++)
      for (int q = 4; q < 20; q++) ref_win[r][q] = 8'h80;
    for (int r = 3; r < 19; r++)
      for (int q = 6; q < 22; q++) ref_win[r][q] = 8'h80;
    ref_win[3][20] = 8'hBC;
    ref_win[19][4] = 8'hE4;
    load_cur();
    pulse_start();
    send_window();
    wait_done(lat);
    checks++;
    if (lat !== 66 || best_sad !== exp_sad || best_mvx !== exp_mvx || best_mvy !== exp_mvy) begin
      errors++;
      $display("FAIL zero_bias: lat=%0d sad=%0d mvx=%h mvy=%h expected lat=66 sad=%0d mvx=%h mvy=%h",
               lat, best_sad, best_mvx, best_mvy, exp_sad, exp_mvx, exp_mvy);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cur_in    = '0;
    cur_we    = 1'b0;
    cur_addr  = '0;
    start     = 1'b0;
    ref_row   = '0;
    ref_valid = 1'b0;
    ref_first = 1'b0;
    test_reset();
    test_flat();
    test_exact_match();
    test_max_sad();
    test_gaps_restart();
    test_reset_in_compare();
    test_zero_bias();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
